// File: rtl/riscv_core_pkg.sv
// Core-wide constants and basic types shared by the integer register file and its neighbours.
package riscv_core_pkg;

  localparam int XLEN           = 32;
  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
  localparam int RF_NUM_RD      = 4;
  localparam int RF_NUM_WR      = 2;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]           word_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bundle of decode-side reads/allocations and write-back-side writes for reg_file_mp.
interface reg_file_mp_if
  import riscv_core_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int CNT_WIDTH  = $clog2(REG_COUNT + 1),
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int NUM_WR     = RF_NUM_WR
);

  logic [NUM_WR-1:0]                 wr_en_i;
  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wr_addr_i;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data_i;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr_i;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_o;
  logic [NUM_RD-1:0]                 rd_busy_o;
  logic [NUM_WR-1:0]                 alloc_en_i;
  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] alloc_addr_i;
  logic                              flush_i;
  logic [CNT_WIDTH-1:0]              pending_cnt_o;
  logic                              wr_collision_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, alloc_en_i, alloc_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, pending_cnt_o, wr_collision_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, alloc_en_i, alloc_addr_i, flush_i,
    output rd_data_o, rd_busy_o, pending_cnt_o, wr_collision_o
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register write-pending bits: allocation by issue, clearing by write-back, global flush,
// plus the registered pending count and the per-read-port busy lookup.
module reg_scoreboard #(
  parameter int REG_COUNT   = riscv_core_pkg::REG_COUNT,
  parameter int NUM_WR      = riscv_core_pkg::RF_NUM_WR,
  parameter int NUM_RD      = riscv_core_pkg::RF_NUM_RD,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NUM_WR-1:0]                          wr_en_i,
  input  logic [NUM_WR-1:0][$clog2(REG_COUNT)-1:0]   wr_addr_i,
  input  logic [NUM_WR-1:0]                          alloc_en_i,
  input  logic [NUM_WR-1:0][$clog2(REG_COUNT)-1:0]   alloc_addr_i,
  input  logic                                       flush_i,
  input  logic [NUM_RD-1:0][$clog2(REG_COUNT)-1:0]   rd_addr_i,
  input  logic [NUM_RD-1:0]                          rd_fwd_i,
  output logic [NUM_RD-1:0]                          rd_busy_o,
  output logic [$clog2(REG_COUNT+1)-1:0]             pending_cnt_o
);

  localparam int ADDR_W = $clog2(REG_COUNT);
  localparam int CNT_W  = $clog2(REG_COUNT + 1);

  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Alloc is applied after clear so the newer producer wins on the same register.
  always_comb begin
    pending_d = pending_q;
    for (int r = 0; r < REG_COUNT; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en_i[p] && wr_addr_i[p] == ADDR_W'(r)) pending_d[r] = 1'b0;
      end
      for (int p = 0; p < NUM_WR; p++) begin
        if (alloc_en_i[p] && alloc_addr_i[p] == ADDR_W'(r)) pending_d[r] = 1'b1;
      end
    end
    if (flush_i) pending_d = '0;
    if (ZERO_REG_EN != 0) pending_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < REG_COUNT; r++) cnt_d = cnt_d + CNT_W'(pending_d[r]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy_o[k] = pending_q[rd_addr_i[k]] & ~rd_fwd_i[k];
      if (ZERO_REG_EN != 0 && rd_addr_i[k] == '0) rd_busy_o[k] = 1'b0;
    end
  end

  assign pending_cnt_o = cnt_q;

  for (genvar p = 0; p < NUM_WR; p++) begin : g_alloc_chk
    a_no_zero_alloc: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(ZERO_REG_EN != 0 && alloc_en_i[p] && alloc_addr_i[p] == '0));
  end

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CNT_W'(REG_COUNT - ZERO_REG_EN));

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: storage, write arbitration (highest port wins),
// optional write-first bypass, collision flag, and the embedded pending scoreboard.
module reg_file_mp #(
  parameter int DATA_WIDTH     = riscv_core_pkg::XLEN,
  parameter int REG_COUNT      = riscv_core_pkg::REG_COUNT,
  parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int NUM_RD         = riscv_core_pkg::RF_NUM_RD,
  parameter int NUM_WR         = riscv_core_pkg::RF_NUM_WR,
  parameter int BYPASS_EN      = 1,
  parameter int ZERO_REG_EN    = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  reg_file_mp_if.slave  bus
);

  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

  data_t                   mem_q [REG_COUNT];
  data_t [NUM_RD-1:0]      rd_data;
  logic  [NUM_RD-1:0]      rd_fwd;
  logic                    collision_d, collision_q;

  function automatic logic is_zero_reg(addr_t a);
    return (ZERO_REG_EN != 0) && (a == '0);
  endfunction

  // Later ports are assigned last, so the highest-index port wins an address collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < REG_COUNT; r++) mem_q[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (bus.wr_en_i[p] && !is_zero_reg(bus.wr_addr_i[p]))
          mem_q[bus.wr_addr_i[p]] <= bus.wr_data_i[p];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_fwd  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k] = mem_q[bus.rd_addr_i[k]];
      if (BYPASS_EN != 0) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (bus.wr_en_i[p] && bus.wr_addr_i[p] == bus.rd_addr_i[k]) begin
            rd_data[k] = bus.wr_data_i[p];
            rd_fwd[k]  = 1'b1;
          end
        end
      end
      if (is_zero_reg(bus.rd_addr_i[k])) rd_data[k] = '0;
    end
  end

  always_comb begin
    collision_d = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (bus.wr_en_i[p] && bus.wr_en_i[q] && bus.wr_addr_i[p] == bus.wr_addr_i[q]
            && !is_zero_reg(bus.wr_addr_i[p]))
          collision_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) collision_q <= 1'b0;
    else         collision_q <= collision_d;
  end

  assign bus.rd_data_o      = rd_data;
  assign bus.wr_collision_o = collision_q;

  reg_scoreboard #(
    .REG_COUNT   (REG_COUNT),
    .NUM_WR      (NUM_WR),
    .NUM_RD      (NUM_RD),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wr_en_i       (bus.wr_en_i),
    .wr_addr_i     (bus.wr_addr_i),
    .alloc_en_i    (bus.alloc_en_i),
    .alloc_addr_i  (bus.alloc_addr_i),
    .flush_i       (bus.flush_i),
    .rd_addr_i     (bus.rd_addr_i),
    .rd_fwd_i      (rd_fwd),
    .rd_busy_o     (bus.rd_busy_o),
    .pending_cnt_o (bus.pending_cnt_o)
  );

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file with an integrated write-pending scoreboard, successor to the single-write RV32 register file. Serves a dual-issue decode/write-back pair: N combinational read ports, M synchronous write ports with optional write-to-read bypass, and per-register pending bits that let issue logic stall on RAW hazards. Sits between decode (reads, allocation) and write-back (writes) in the core.

## Interface
- DATA_WIDTH, 32, register width
- REG_COUNT, 32, number of architectural registers; power of two, at least 2
- REG_ADDR_WIDTH, $clog2(REG_COUNT), address width
- NUM_RD, 4, read ports
- NUM_WR, 2, write ports
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to reads (write-first); 0 = read-before-write
- ZERO_REG_EN, 1, 1 = register 0 hardwired to zero, never pending
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- wr_en_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR x REG_ADDR_WIDTH  write addresses
- wr_data_i  in  NUM_WR x DATA_WIDTH  write data
- rd_addr_i  in  NUM_RD x REG_ADDR_WIDTH  read addresses
- rd_data_o  out  NUM_RD x DATA_WIDTH  read data, combinational
- rd_busy_o  out  NUM_RD  read register has an outstanding producer
- alloc_en_i  in  NUM_WR  mark destination pending, driven by the issue stage
- alloc_addr_i  in  NUM_WR x REG_ADDR_WIDTH  destinations to mark
- flush_i  in  1  clear all pending bits; register contents are kept
- pending_cnt_o  out  $clog2(REG_COUNT+1)  number of registers currently pending, registered
- wr_collision_o  out  1  registered flag: two enabled write ports targeted the same non-zero address in the previous cycle

## Operation
- Reset: all registers 0, all pending bits 0, pending_cnt_o = 0, wr_collision_o = 0. rd_data_o and rd_busy_o follow from the cleared state. Reset asserted mid-operation discards in-flight writes and allocations in that cycle.
- Write: on the clock edge, each enabled port writes its data. On an address collision, the highest-index port wins. When ZERO_REG_EN = 1, writes to address 0 are dropped silently and do not count as collisions.
- Read: rd_data_o[k] = 0 if ZERO_REG_EN = 1 and address = 0. Otherwise, if BYPASS_EN = 1 and an enabled write targets the same address this cycle, the output is the highest-index matching wr_data_i. Otherwise it is the stored value.
- Scoreboard, next-state per register r, evaluated in priority order:
  - flush_i: pending = 0 for all registers, overriding everything else.
  - Any alloc_en_i to r: pending = 1. Alloc beats a same-cycle write to r, because the allocating instruction is the newer producer.
  - Otherwise, any enabled write to r: pending = 0.
  - Otherwise: hold.
  - Register 0 is never pending when ZERO_REG_EN = 1.
- rd_busy_o[k] = pending[rd_addr_i[k]], with these exceptions:
  - It is forced to 0 when BYPASS_EN = 1 and a same-cycle write hits the address, since the data is forwarded.
  - It is forced to 0 for address 0 when ZERO_REG_EN = 1.
- pending_cnt_o = population count of the next-state pending vector, registered.
- Two alloc ports targeting the same register are legal and set the bit once.

## Timing
- Read data: 0 cycles (combinational from rd_addr_i, and from the write ports when BYPASS_EN = 1).
- Write visible to stored reads: next cycle. Visible same cycle with BYPASS_EN = 1.
- Alloc: rd_busy_o rises the cycle after alloc_en_i.
- Write: clears busy the next cycle, or the same cycle via bypass.
- Flush: pending_cnt_o = 0 and rd_busy_o = 0 the cycle after flush_i.
- wr_collision_o: one cycle after the colliding writes, high for one cycle per colliding cycle.

## Structure
- Shared package riscv_core_pkg owns:
  - XLEN, REG_COUNT and REG_ADDR_WIDTH as default sources.
  - RF_NUM_RD and RF_NUM_WR constants.
  - reg_addr_t and word_t.
- Sub-module reg_scoreboard holds the pending vector, alloc/clear/flush priority, popcount and busy lookup. Parameters: REG_COUNT, NUM_WR, NUM_RD, ZERO_REG_EN.
- Storage array, write arbitration, bypass muxes and collision detection live in reg_file_mp.
- Non-synthesis assertions:
  - No alloc of register 0 when ZERO_REG_EN = 1.
  - pending_cnt_o never exceeds REG_COUNT − ZERO_REG_EN.

## Test plan
- Reset: assert rst_ni low mid-write with wr_en_i[0] = 1, addr 5, data 0xDEAD → after release, reading addr 5 gives 0, pending_cnt_o = 0, all rd_busy_o = 0.
- Dual write: port 0 writes 3 ← 0x11, port 1 writes 7 ← 0x22 → next cycle, reads of 3 and 7 give 0x11 and 0x22. Same-cycle read of 7 gives 0x22 when BYPASS_EN = 1, old value when BYPASS_EN = 0.
- Collision: both ports write addr 9, with 0xAAAA on port 0 and 0xBBBB on port 1 → addr 9 reads 0xBBBB and wr_collision_o = 1 for one cycle. Both ports writing addr 0 → no collision, addr 0 reads 0.
- Scoreboard:
  - Alloc 4 → rd_busy_o for addr 4 = 1 and pending_cnt_o = 1 the next cycle.
  - Write 4 → busy = 0 in the same cycle (bypass on), count 0 the next cycle.
  - Alloc 4 and write 4 in the same cycle → remains pending.
- Flush: alloc 1, 2, 3 over two cycles, then flush_i together with alloc 5 → next cycle pending_cnt_o = 0 and addr 5 not busy.
- Zero register: write 0 ← 0xFFFF and alloc 0 with ZERO_REG_EN = 1 → addr 0 reads 0, busy 0, count unchanged.
